// File: rtl/imem_resp.sv
// Instruction-memory responder: accepts one fetch at a time, waits LATENCY cycles,
// then presents the instruction word (or an error flag) until decode takes it.
module imem_resp #(
  parameter int                   CPU_WIDTH = 32,
  parameter int                   DEPTH     = 1024,
  parameter int                   LATENCY   = 2,
  parameter logic [CPU_WIDTH-1:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [CPU_WIDTH-1:0]     i_req_addr,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [CPU_WIDTH-1:0]     o_rsp_inst,
  output logic                     o_rsp_err,
  input  logic                     i_ld_en,
  input  logic [$clog2(DEPTH)-1:0] i_ld_idx,
  input  logic [CPU_WIDTH-1:0]     i_ld_data,
  output logic                     o_busy
);

  localparam int                   IDX_W       = $clog2(DEPTH);
  localparam bit                   LAT_ONE     = (LATENCY == 1);
  localparam logic [3:0]           CNT_LOAD    = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [CPU_WIDTH-1:0] DEPTH_WORDS = CPU_WIDTH'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [3:0]           cnt_r;
  logic [3:0]           cnt_nxt_s;
  logic [CPU_WIDTH-1:0] addr_r;
  logic [CPU_WIDTH-1:0] addr_nxt_s;

  logic                 req_ready_r;
  logic                 busy_r;
  logic                 rsp_valid_r;
  logic [CPU_WIDTH-1:0] rsp_inst_r;
  logic                 rsp_err_r;
  logic [CPU_WIDTH-1:0] rsp_inst_nxt_s;
  logic                 rsp_err_nxt_s;

  logic                 ld_we_s;
  logic [CPU_WIDTH-1:0] lookup_addr_s;
  logic [CPU_WIDTH-1:0] lkp_word_s;
  logic [IDX_W-1:0]     lkp_idx_s;
  logic                 lkp_err_s;
  logic [CPU_WIDTH-1:0] rd_data_s;

  logic [CPU_WIDTH-1:0] mem_r [DEPTH];

  // Loads only land while idle so an in-flight response never sees a changing word.
  assign ld_we_s = (state_r == ST_IDLE) && i_ld_en;

  // With LATENCY==1 the array is read on the accept edge, before addr_r holds the address.
  assign lookup_addr_s = (state_r == ST_IDLE) ? i_req_addr : addr_r;
  assign lkp_word_s    = (lookup_addr_s - BASE_ADDR) >> 2;
  assign lkp_idx_s     = lkp_word_s[IDX_W-1:0];
  assign lkp_err_s     = (lookup_addr_s[1:0] != 2'b00) || (lkp_word_s >= DEPTH_WORDS);

  // Array read, forwarding a same-cycle backdoor load to the word being fetched.
  always_comb begin
    rd_data_s = mem_r[lkp_idx_s];
    if (ld_we_s && (i_ld_idx == lkp_idx_s)) begin
      rd_data_s = i_ld_data;
    end else begin
      rd_data_s = mem_r[lkp_idx_s];
    end
  end

  // Backdoor write port; array contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (ld_we_s) begin
      mem_r[i_ld_idx] <= i_ld_data;
    end
  end

  // Next-state logic: IDLE accepts, WAIT counts down, RESP holds until taken.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    addr_nxt_s  = addr_r;
    case (state_r)
      ST_IDLE: begin
        if (i_req_valid) begin
          addr_nxt_s = i_req_addr;
          if (LAT_ONE) begin
            state_nxt_s = ST_RESP;
          end else begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = CNT_LOAD;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = ST_RESP;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // Response payload is captured only on the edge that enters RESP, then held.
  always_comb begin
    rsp_inst_nxt_s = rsp_inst_r;
    rsp_err_nxt_s  = rsp_err_r;
    if ((state_nxt_s == ST_RESP) && (state_r != ST_RESP)) begin
      if (lkp_err_s) begin
        rsp_inst_nxt_s = {CPU_WIDTH{1'b0}};
        rsp_err_nxt_s  = 1'b1;
      end else begin
        rsp_inst_nxt_s = rd_data_s;
        rsp_err_nxt_s  = 1'b0;
      end
    end else begin
      rsp_inst_nxt_s = rsp_inst_r;
      rsp_err_nxt_s  = rsp_err_r;
    end
  end

  // State, counter, latched address and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      addr_r      <= {CPU_WIDTH{1'b0}};
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_inst_r  <= {CPU_WIDTH{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      addr_r      <= addr_nxt_s;
      req_ready_r <= (state_nxt_s == ST_IDLE);
      busy_r      <= (state_nxt_s != ST_IDLE);
      rsp_valid_r <= (state_nxt_s == ST_RESP);
      rsp_inst_r  <= rsp_inst_nxt_s;
      rsp_err_r   <= rsp_err_nxt_s;
    end
  end

  assign o_req_ready = req_ready_r;
  assign o_busy      = busy_r;
  assign o_rsp_valid = rsp_valid_r;
  assign o_rsp_inst  = rsp_inst_r;
  assign o_rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_imem_resp.sv
// Self-checking bench for imem_resp: a LATENCY=2 instance for the main scenarios and a
// LATENCY=1 instance for single-cycle timing and back-to-back issue.
module tb_imem_resp;

  localparam logic [31:0] BASE = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  // LATENCY=2 instance
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, ld_en, busy;
  logic [31:0] req_addr, rsp_inst, ld_data;
  logic [9:0]  ld_idx;
  // LATENCY=1 instance
  logic        req_valid1, req_ready1, rsp_valid1, rsp_ready1, rsp_err1, ld_en1, busy1;
  logic [31:0] req_addr1, rsp_inst1, ld_data1;
  logic [9:0]  ld_idx1;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_mem [1024];
  exp_t sb_q[$];
  exp_t sb1_q[$];

  always #5 clk = ~clk;

  imem_resp #(.CPU_WIDTH(32), .DEPTH(1024), .LATENCY(2), .BASE_ADDR(BASE)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_inst(rsp_inst), .o_rsp_err(rsp_err),
    .i_ld_en(ld_en), .i_ld_idx(ld_idx), .i_ld_data(ld_data), .o_busy(busy)
  );

  imem_resp #(.CPU_WIDTH(32), .DEPTH(1024), .LATENCY(1), .BASE_ADDR(BASE)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid1), .o_req_ready(req_ready1), .i_req_addr(req_addr1),
    .o_rsp_valid(rsp_valid1), .i_rsp_ready(rsp_ready1), .o_rsp_inst(rsp_inst1), .o_rsp_err(rsp_err1),
    .i_ld_en(ld_en1), .i_ld_idx(ld_idx1), .i_ld_data(ld_data1), .o_busy(busy1)
  );

  function automatic exp_t model_rsp(input logic [31:0] addr);
    exp_t        e;
    logic [31:0] word;
    word = (addr - BASE) >> 2;
    if ((addr[1:0] != 2'b00) || (word >= 32'd1024)) begin
      e.inst = 32'h0;
      e.err  = 1'b1;
    end else begin
      e.inst = model_mem[word[9:0]];
      e.err  = 1'b0;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [9:0] idx, input logic [31:0] data);
    ld_en = 1'b1; ld_idx = idx; ld_data = data;
    model_mem[idx] = data;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b0; ld_en = 1'b0; ld_idx = 10'd0; ld_data = 32'h0;
    req_valid1 = 1'b0; req_addr1 = 32'h0; rsp_ready1 = 1'b0; ld_en1 = 1'b0; ld_idx1 = 10'd0; ld_data1 = 32'h0;
    tick(); tick();
    checks++;
    if ({req_ready, rsp_valid, rsp_err, busy} !== 4'b1000 || rsp_inst !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b valid=%b err=%b busy=%b inst=%h, expected 1 0 0 0 00000000",
               req_ready, rsp_valid, rsp_err, busy, rsp_inst);
    end
    checks++;
    if ({req_ready1, rsp_valid1, rsp_err1, busy1} !== 4'b1000 || rsp_inst1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_state_lat1: got ready=%b valid=%b err=%b busy=%b inst=%h, expected 1 0 0 0 00000000",
               req_ready1, rsp_valid1, rsp_err1, busy1, rsp_inst1);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    exp_t e;
    load(10'd0, 32'h0050_0093);
    req_addr = BASE; req_valid = 1'b1; rsp_ready = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL basic_accept: ready=%b, expected 1", req_ready);
    end
    sb_q.push_back(model_rsp(BASE));
    tick(); req_valid = 1'b0;                       // T+1
    checks++;
    if ({rsp_valid, busy, req_ready} !== 3'b010) begin
      errors++; $display("FAIL basic_t1: valid/busy/ready=%b%b%b, expected 010", rsp_valid, busy, req_ready);
    end
    tick();                                         // T+2
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL basic_t2_valid: valid=%b, expected 1", rsp_valid);
    end
    e = sb_q.pop_front();
    checks++;
    if (rsp_inst !== e.inst || rsp_err !== e.err) begin
      errors++; $display("FAIL basic_data: got inst=%h err=%b, expected inst=%h err=%b", rsp_inst, rsp_err, e.inst, e.err);
    end
    tick();                                         // T+3
    checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      errors++; $display("FAIL basic_t3: ready/valid=%b%b, expected 10", req_ready, rsp_valid);
    end
  endtask

  task automatic test_hold();
    exp_t e;
    load(10'd1, 32'h0010_8113);
    req_addr = BASE + 32'd4; req_valid = 1'b1; rsp_ready = 1'b0;
    sb_q.push_back(model_rsp(BASE + 32'd4));
    tick(); req_valid = 1'b0;
    tick();                                         // first RESP cycle
    e = sb_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_inst !== e.inst || rsp_err !== e.err || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%b inst=%h err=%b ready=%b, expected 1 %h %b 0",
                 i, rsp_valid, rsp_inst, rsp_err, req_ready, e.inst, e.err);
      end
      req_valid = 1'b1; req_addr = BASE;
      tick();
    end
    rsp_ready = 1'b1;                               // handshake cycle, request still offered
    checks++;
    if (rsp_valid !== 1'b1 || rsp_inst !== e.inst || rsp_err !== e.err) begin
      errors++; $display("FAIL hold_release: valid=%b inst=%h err=%b, expected 1 %h %b", rsp_valid, rsp_inst, rsp_err, e.inst, e.err);
    end
    tick(); req_valid = 1'b0;
    checks++;
    if ({req_ready, busy, rsp_valid} !== 3'b100) begin
      errors++; $display("FAIL hold_idle: ready/busy/valid=%b%b%b, expected 100", req_ready, busy, rsp_valid);
    end
    tick();
    checks++;
    if ({busy, rsp_valid} !== 2'b00) begin
      errors++; $display("FAIL hold_no_accept: busy/valid=%b%b, expected 00", busy, rsp_valid);
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [4];
    exp_t        e;
    bit          ok;
    load(10'd1023, 32'h1234_5678);
    addrs[0] = BASE + 32'd2;
    addrs[1] = BASE + 32'h0000_1000;
    addrs[2] = 32'h7FFF_FFFC;
    addrs[3] = BASE + 32'h0000_0FFC;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = addrs[i]; req_valid = 1'b1;
      sb_q.push_back(model_rsp(addrs[i]));
      tick(); req_valid = 1'b0;
      wait_valid(ok);
      e = sb_q.pop_front();
      checks++;
      if (!ok) begin
        errors++; $display("FAIL err_timeout addr=%h: no response within bound", addrs[i]);
      end else if (rsp_inst !== e.inst || rsp_err !== e.err) begin
        errors++; $display("FAIL err_resp addr=%h: got inst=%h err=%b, expected inst=%h err=%b",
                           addrs[i], rsp_inst, rsp_err, e.inst, e.err);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   ok;
    req_addr = BASE; req_valid = 1'b1; rsp_ready = 1'b1;
    tick(); req_valid = 1'b0;                       // WAIT
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_busy: busy=%b, expected 1", busy);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({rsp_valid, req_ready, busy} !== 3'b010) begin
      errors++; $display("FAIL rstmid_state: valid/ready/busy=%b%b%b, expected 010", rsp_valid, req_ready, busy);
    end
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_dropped: valid=%b, expected 0", rsp_valid);
    end
    req_addr = BASE; req_valid = 1'b1;
    sb_q.push_back(model_rsp(BASE));
    tick(); req_valid = 1'b0;
    wait_valid(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || rsp_inst !== e.inst || rsp_err !== e.err) begin
      errors++; $display("FAIL rstmid_mem: ok=%b inst=%h err=%b, expected inst=%h err=%b", ok, rsp_inst, rsp_err, e.inst, e.err);
    end
    tick();
  endtask

  task automatic test_ld_during_wait();
    exp_t e;
    bit   ok;
    req_addr = BASE; req_valid = 1'b1; rsp_ready = 1'b1;
    sb_q.push_back(model_rsp(BASE));
    tick(); req_valid = 1'b0;
    ld_en = 1'b1; ld_idx = 10'd0; ld_data = 32'hDEAD_BEEF;    // must be ignored
    tick(); ld_en = 1'b0;
    e = sb_q.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_inst !== e.inst || rsp_err !== e.err) begin
      errors++; $display("FAIL ldwait_resp: valid=%b inst=%h err=%b, expected 1 %h %b", rsp_valid, rsp_inst, rsp_err, e.inst, e.err);
    end
    tick();
    req_addr = BASE; req_valid = 1'b1;
    sb_q.push_back(model_rsp(BASE));
    tick(); req_valid = 1'b0;
    wait_valid(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || rsp_inst !== e.inst || rsp_err !== e.err) begin
      errors++; $display("FAIL ldwait_reread: ok=%b inst=%h, expected inst=%h", ok, rsp_inst, e.inst);
    end
    tick();
    // load and accept in the same idle cycle: new data comes back
    ld_en = 1'b1; ld_idx = 10'd2; ld_data = 32'h2222_2222; model_mem[2] = 32'h2222_2222;
    req_addr = BASE + 32'd8; req_valid = 1'b1;
    sb_q.push_back(model_rsp(BASE + 32'd8));
    tick(); ld_en = 1'b0; req_valid = 1'b0;
    wait_valid(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || rsp_inst !== e.inst || rsp_err !== e.err) begin
      errors++; $display("FAIL ld_same_cycle: ok=%b inst=%h, expected inst=%h", ok, rsp_inst, e.inst);
    end
    tick();
  endtask

  task automatic test_lat1();
    exp_t e;
    ld_en1 = 1'b1; ld_idx1 = 10'd0; ld_data1 = 32'h0050_0093; tick();
    ld_idx1 = 10'd1; ld_data1 = 32'h0010_8113; tick();
    ld_en1 = 1'b0;
    req_addr1 = BASE; req_valid1 = 1'b1; rsp_ready1 = 1'b1;
    checks++;
    if (req_ready1 !== 1'b1) begin
      errors++; $display("FAIL lat1_accept: ready=%b, expected 1", req_ready1);
    end
    sb1_q.push_back(model_rsp(BASE));
    tick(); req_valid1 = 1'b0;                      // T+1
    e = sb1_q.pop_front();
    checks++;
    if (rsp_valid1 !== 1'b1 || rsp_inst1 !== e.inst || rsp_err1 !== e.err) begin
      errors++; $display("FAIL lat1_resp: valid=%b inst=%h err=%b, expected 1 %h %b", rsp_valid1, rsp_inst1, rsp_err1, e.inst, e.err);
    end
    tick();
    // same-cycle load forwarded to a single-cycle fetch
    ld_en1 = 1'b1; ld_idx1 = 10'd3; ld_data1 = 32'hCAFE_F00D; model_mem[3] = 32'hCAFE_F00D;
    req_addr1 = BASE + 32'd12; req_valid1 = 1'b1;
    sb1_q.push_back(model_rsp(BASE + 32'd12));
    tick(); ld_en1 = 1'b0; req_valid1 = 1'b0;
    e = sb1_q.pop_front();
    checks++;
    if (rsp_valid1 !== 1'b1 || rsp_inst1 !== e.inst || rsp_err1 !== e.err) begin
      errors++; $display("FAIL lat1_fwd: valid=%b inst=%h, expected 1 %h", rsp_valid1, rsp_inst1, e.inst);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   n_acc;
    int   prev;
    n_acc = 0; prev = -1;
    req_valid1 = 1'b1; rsp_ready1 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      req_addr1 = BASE + 32'(4 * (n_acc % 2));
      if (rsp_valid1 === 1'b1) begin
        checks++;
        if (sb1_q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected_rsp: cycle %0d inst=%h, expected no response", c, rsp_inst1);
        end else begin
          e = sb1_q.pop_front();
          if (rsp_inst1 !== e.inst || rsp_err1 !== e.err) begin
            errors++; $display("FAIL b2b_data: cycle %0d inst=%h err=%b, expected %h %b", c, rsp_inst1, rsp_err1, e.inst, e.err);
          end
        end
      end
      if (req_ready1 === 1'b1) begin
        if (prev >= 0) begin
          checks++;
          if (c - prev !== 2) begin
            errors++; $display("FAIL b2b_interval: got %0d cycles, expected 2", c - prev);
          end
        end
        prev = c;
        n_acc++;
        sb1_q.push_back(model_rsp(req_addr1));
      end
      tick();
    end
    req_valid1 = 1'b0;
    checks++;
    if (n_acc !== 6 || sb1_q.size() != 0) begin
      errors++; $display("FAIL b2b_count: accepts=%0d pending=%0d, expected 6 and 0", n_acc, sb1_q.size());
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_errors();
    test_reset_mid();
    test_ld_during_wait();
    test_lat1();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
